fft8_input_loader: RTL

Upstream front end of the 8-point FFT datapath. Accepts real samples serially over a valid/ready handshake and assembles 8-sample frames in bit-reversed order. Presents each frame as eight parallel words to the first butterfly stage. Ping-pong banks let one frame fill while the previous frame waits for the datapath to accept it.

---
 rtl/fft8_input_loader_if.sv | 36 +++
 rtl/fft8_input_loader.sv | 77 +++++++
 2 files changed

// File: rtl/fft8_input_loader_if.sv
// Sample-in / frame-out bundle for the FFT8 input loader.
// The slave side is the loader; the master side is its environment.
interface fft8_input_loader_if #(
    parameter int N = 4
) ();
    localparam int W = 2 ** N;

    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;

    logic [W-1:0] out_0;
    logic [W-1:0] out_1;
    logic [W-1:0] out_2;
    logic [W-1:0] out_3;
    logic [W-1:0] out_4;
    logic [W-1:0] out_5;
    logic [W-1:0] out_6;
    logic [W-1:0] out_7;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_valid,
        input  out_0, out_1, out_2, out_3,
        input  out_4, out_5, out_6, out_7
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_valid,
        output out_0, out_1, out_2, out_3,
        output out_4, out_5, out_6, out_7
    );
endinterface

// File: rtl/fft8_input_loader.sv
// FFT8 input loader: serial samples into ping-pong banks,
// stored bit-reversed and presented as one parallel frame.
module fft8_input_loader #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fft8_input_loader_if.slave    bus
);
    localparam int W = 2 ** N;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    logic [1:0][7:0][W-1:0] bank_q;
    logic                   wr_bank_q, wr_bank_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [2:0]             wr_cnt_q, wr_cnt_d;
    logic [1:0]             full_q, full_d;

    logic in_ready;
    logic wr_fire;
    logic rd_fire;

    always_comb begin
        in_ready  = !full_q[wr_bank_q];
        wr_fire   = bus.in_valid && in_ready;
        rd_fire   = full_q[rd_bank_q] && bus.out_ready;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        full_d    = full_q;
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 3'd1;
            if (wr_cnt_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        // Completion and release always hit different banks.
        if (rd_fire) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= 3'd0;
            full_q    <= 2'b00;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            full_q    <= full_d;
            if (wr_fire) begin
                bank_q[wr_bank_q][bitrev3(wr_cnt_q)] <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = full_q[rd_bank_q];

    assign bus.out_0 = bank_q[rd_bank_q][0];
    assign bus.out_1 = bank_q[rd_bank_q][1];
    assign bus.out_2 = bank_q[rd_bank_q][2];
    assign bus.out_3 = bank_q[rd_bank_q][3];
    assign bus.out_4 = bank_q[rd_bank_q][4];
    assign bus.out_5 = bank_q[rd_bank_q][5];
    assign bus.out_6 = bank_q[rd_bank_q][6];
    assign bus.out_7 = bank_q[rd_bank_q][7];
endmodule
